// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction memory loader.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN_HI,
        LEN_LO,
        DATA,
        CHECK,
        DONE,
        ERROR
    } loader_state_t;

    localparam logic [7:0] CHECKSUM_INIT    = 8'h00;
    localparam int         LOADER_LEN_BYTES = 2;

endpackage

// File: rtl/imem_loader_if.sv
// Host byte stream (valid/ready) plus the imem write port driven by the loader.
interface imem_loader_if #(
    parameter int ADDR_WIDTH = 10
);
    logic [7:0]            rx_data;
    logic                  rx_valid;
    logic                  rx_ready;
    logic                  imem_we;
    logic [ADDR_WIDTH-1:0] imem_addr;
    logic [31:0]           imem_wd;

    modport master (output rx_data, rx_valid, input rx_ready, imem_we, imem_addr, imem_wd);
    modport slave  (input rx_data, rx_valid, output rx_ready, imem_we, imem_addr, imem_wd);
endinterface

// File: rtl/imem_loader_word_assembler.sv
// Packs four big-endian bytes into a 32-bit word; word_valid pulses one cycle
// after the fourth byte and word_out holds the word until the next one.
module imem_loader_word_assembler (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_in,
    output logic [1:0]  byte_idx,
    output logic        word_valid,
    output logic [31:0] word_out
);
    logic [23:0] hi_bytes;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            byte_idx   <= 2'd0;
            hi_bytes   <= 24'd0;
            word_valid <= 1'b0;
            word_out   <= 32'd0;
        end else begin
            word_valid <= 1'b0;
            if (clear) begin
                byte_idx <= 2'd0;
                hi_bytes <= 24'd0;
            end else if (byte_valid) begin
                byte_idx <= byte_idx + 2'd1;
                case (byte_idx)
                    2'd0:    hi_bytes[23:16] <= byte_in;
                    2'd1:    hi_bytes[15:8]  <= byte_in;
                    2'd2:    hi_bytes[7:0]   <= byte_in;
                    default: begin
                        word_out   <= {hi_bytes, byte_in};
                        word_valid <= 1'b1;
                    end
                endcase
            end
        end
    end
endmodule

// File: rtl/imem_loader.sv
// Boot loader: parses LEN/data/checksum frames, writes imem sequentially and
// releases cpu_hold only once the XOR checksum of the data bytes matches.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int BASE_ADDR  = 0
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    imem_loader_if.slave        bus,
    output logic                cpu_hold,
    output logic                done,
    output logic                error,
    output logic [ADDR_WIDTH:0] words_written
);
    loader_state_t                 state;
    logic [8*LOADER_LEN_BYTES-1:0] len;
    logic [8*LOADER_LEN_BYTES-1:0] len_next;
    logic [7:0]                    csum;
    logic [ADDR_WIDTH-1:0]         addr;
    logic [1:0]                    byte_idx;
    logic                          accept, restart, last_word;

    assign bus.rx_ready = (state == LEN_HI) || (state == LEN_LO) ||
                          (state == DATA)   || (state == CHECK);
    assign accept    = bus.rx_valid && bus.rx_ready;
    assign restart   = start && ((state == IDLE) || (state == DONE) || (state == ERROR));
    assign len_next  = {len[15:8], bus.rx_data};
    // Write count lags acceptance by two cycles but words are >= 4 cycles apart.
    assign last_word = (32'(words_written) + 32'd1) == 32'(len);
    assign bus.imem_addr = addr;

    imem_loader_word_assembler u_asm (
        .clk        (clk),
        .reset_n    (reset_n),
        .clear      (restart),
        .byte_valid (accept && (state == DATA)),
        .byte_in    (bus.rx_data),
        .byte_idx   (byte_idx),
        .word_valid (bus.imem_we),
        .word_out   (bus.imem_wd)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            len           <= '0;
            csum          <= CHECKSUM_INIT;
            addr          <= ADDR_WIDTH'(BASE_ADDR);
            words_written <= '0;
            cpu_hold      <= 1'b1;
            done          <= 1'b0;
            error         <= 1'b0;
        end else begin
            if (bus.imem_we) begin
                addr          <= addr + ADDR_WIDTH'(1);
                words_written <= words_written + (ADDR_WIDTH+1)'(1);
            end
            case (state)
                IDLE, DONE, ERROR: if (start) begin
                    state         <= LEN_HI;
                    csum          <= CHECKSUM_INIT;
                    addr          <= ADDR_WIDTH'(BASE_ADDR);
                    words_written <= '0;
                    cpu_hold      <= 1'b1;
                    done          <= 1'b0;
                    error         <= 1'b0;
                end
                LEN_HI: if (accept) begin
                    len[15:8] <= bus.rx_data;
                    state     <= LEN_LO;
                end
                LEN_LO: if (accept) begin
                    len[7:0] <= bus.rx_data;
                    if (32'(len_next) > (32'd1 << ADDR_WIDTH)) begin
                        state <= ERROR;
                        error <= 1'b1;
                    end else if (len_next == '0) begin
                        state <= CHECK;
                    end else begin
                        state <= DATA;
                    end
                end
                DATA: if (accept) begin
                    csum <= csum ^ bus.rx_data;
                    if (byte_idx == 2'd3 && last_word) state <= CHECK;
                end
                CHECK: if (accept) begin
                    if (bus.rx_data == csum) begin
                        state    <= DONE;
                        done     <= 1'b1;
                        cpu_hold <= 1'b0;
                    end else begin
                        state <= ERROR;
                        error <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
